// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the never-stalled ALU result stream with buffered load results onto the single register file write port.
// Optional feature macro: WB_ZERO_REG_EN (register 0 is a discard target when defined).
module wb_arbiter #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned REGADDR_WIDTH = 3,
  parameter int unsigned NUM_REGS      = 1 << REGADDR_WIDTH,
  parameter int unsigned FIFO_DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [REGADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [REGADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic                     reg_write,
  output logic [REGADDR_WIDTH-1:0] write_reg,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic [NUM_REGS-1:0]      pending_mask,
  output logic                     order_err
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [REGADDR_WIDTH-1:0] rd_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    valid_q;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;

  logic                     accept_c;
  logic                     push_c;
  logic                     pop_c;
  logic                     alu_wr_c;
  logic                     alu_hit_c;
  logic [NUM_REGS-1:0]      mask_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready depends only on stored occupancy, never on same-cycle pops.
  assign mem_ready = !reset && (count < CNT_W'(FIFO_DEPTH));
  assign accept_c  = mem_valid && mem_ready;

  always_comb begin
    push_c    = accept_c;
    alu_wr_c  = alu_valid;
    alu_hit_c = alu_valid && mask_c[alu_rd];
`ifdef WB_ZERO_REG_EN
    push_c    = accept_c && (mem_rd != '0);
    alu_wr_c  = alu_valid && (alu_rd != '0);
    alu_hit_c = alu_valid && (alu_rd != '0) && mask_c[alu_rd];
`endif
    pop_c     = !alu_valid && (count != '0);
  end

  // Pending registers are the OR of destinations over occupied slots.
  always_comb begin
    mask_c = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (valid_q[i]) mask_c[rd_q[i]] = 1'b1;
    end
  end

  assign pending_mask = reset ? '0 : mask_c;

  always_ff @(posedge clk) begin
    if (push_c) begin
      rd_q[wr_ptr]   <= mem_rd;
      data_q[wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push_c) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop_c) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= ptr_inc(rd_ptr);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Write port: ALU has priority; idle cycles hold address and data.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      order_err  <= 1'b0;
    end else begin
      reg_write <= alu_wr_c || pop_c;
      if (alu_wr_c) begin
        write_reg  <= alu_rd;
        write_data <= alu_data;
      end else if (pop_c) begin
        write_reg  <= rd_q[rd_ptr];
        write_data <= data_q[rd_ptr];
      end
      if (alu_hit_c) order_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; inputs change and outputs are sampled 1ns after each rising edge.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [2:0]  alu_rd;
  logic [15:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [2:0]  mem_rd;
  logic [15:0] mem_data;
  logic        reg_write;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic [7:0]  pending_mask;
  logic        order_err;

  int errors = 0;
  int checks = 0;

  wb_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .pending_mask(pending_mask), .order_err(order_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    step(); step();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL rst_we got=%0b exp=0", reg_write); end
    checks++; if (write_reg !== 3'd0) begin errors++; $display("FAIL rst_wreg got=%0d exp=0", write_reg); end
    checks++; if (write_data !== 16'h0) begin errors++; $display("FAIL rst_wdata got=%h exp=0000", write_data); end
    checks++; if (pending_mask !== 8'h00) begin errors++; $display("FAIL rst_pend got=%h exp=00", pending_mask); end
    checks++; if (order_err !== 1'b0) begin errors++; $display("FAIL rst_oerr got=%0b exp=0", order_err); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%0b exp=0", mem_ready); end
    reset = 1'b0;
    step();
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got=%0b exp=1", mem_ready); end
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL post_rst_we got=%0b exp=0", reg_write); end
  endtask

  task automatic test_alu_stream();
    alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 16'h1234;
    step();
    alu_valid = 1'b0;
    checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL alu_we got=%0b exp=1", reg_write); end
    checks++; if (write_reg !== 3'd3) begin errors++; $display("FAIL alu_wreg got=%0d exp=3", write_reg); end
    checks++; if (write_data !== 16'h1234) begin errors++; $display("FAIL alu_wdata got=%h exp=1234", write_data); end
    step();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL alu_idle_we got=%0b exp=0", reg_write); end
    checks++; if (write_data !== 16'h1234) begin errors++; $display("FAIL alu_hold_wdata got=%h exp=1234", write_data); end
  endtask

  task automatic test_load();
    mem_valid = 1'b1; mem_rd = 3'd5; mem_data = 16'hBEEF;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL load_ready got=%0b exp=1", mem_ready); end
    step();
    mem_valid = 1'b0;
    checks++; if (pending_mask !== 8'h20) begin errors++; $display("FAIL load_pend got=%h exp=20", pending_mask); end
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL load_early_we got=%0b exp=0", reg_write); end
    step();
    checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL load_we got=%0b exp=1", reg_write); end
    checks++; if (write_reg !== 3'd5) begin errors++; $display("FAIL load_wreg got=%0d exp=5", write_reg); end
    checks++; if (write_data !== 16'hBEEF) begin errors++; $display("FAIL load_wdata got=%h exp=beef", write_data); end
    checks++; if (pending_mask !== 8'h00) begin errors++; $display("FAIL load_pend_clr got=%h exp=00", pending_mask); end
    step();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL load_done_we got=%0b exp=0", reg_write); end
  endtask

  task automatic test_contention();
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1'b1; alu_rd = 3'd7; alu_data = 16'h0100 + 16'(k);
      mem_valid = (k < 2);
      mem_rd    = (k == 0) ? 3'd1 : 3'd2;
      mem_data  = (k == 0) ? 16'h0001 : 16'h0002;
      step();
      checks++; if (reg_write !== 1'b1 || write_data !== 16'h0100 + 16'(k))
        begin errors++; $display("FAIL cont_alu%0d got=%0b/%h exp=1/%h", k, reg_write, write_data, 16'h0100 + 16'(k)); end
      checks++; if (mem_ready !== (k == 0))
        begin errors++; $display("FAIL cont_ready%0d got=%0b exp=%0b", k, mem_ready, (k == 0)); end
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    checks++; if (pending_mask !== 8'h06) begin errors++; $display("FAIL cont_pend got=%h exp=06", pending_mask); end
    step();
    checks++; if (reg_write !== 1'b1 || write_reg !== 3'd1 || write_data !== 16'h0001)
      begin errors++; $display("FAIL cont_pop1 got=%0b/%0d/%h exp=1/1/0001", reg_write, write_reg, write_data); end
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL cont_ready_back got=%0b exp=1", mem_ready); end
    checks++; if (pending_mask !== 8'h04) begin errors++; $display("FAIL cont_pend1 got=%h exp=04", pending_mask); end
    step();
    checks++; if (reg_write !== 1'b1 || write_reg !== 3'd2 || write_data !== 16'h0002)
      begin errors++; $display("FAIL cont_pop2 got=%0b/%0d/%h exp=1/2/0002", reg_write, write_reg, write_data); end
    step();
    checks++; if (reg_write !== 1'b0 || pending_mask !== 8'h00)
      begin errors++; $display("FAIL cont_idle got=%0b/%h exp=0/00", reg_write, pending_mask); end
  endtask

  task automatic test_back_to_back();
    mem_valid = 1'b1; mem_rd = 3'd1; mem_data = 16'h0011;
    step();
    mem_rd = 3'd2; mem_data = 16'h0022;
    step();
    mem_valid = 1'b0;
    checks++; if (reg_write !== 1'b1 || write_reg !== 3'd1 || write_data !== 16'h0011)
      begin errors++; $display("FAIL b2b_pop1 got=%0b/%0d/%h exp=1/1/0011", reg_write, write_reg, write_data); end
    checks++; if (pending_mask !== 8'h04) begin errors++; $display("FAIL b2b_pend got=%h exp=04", pending_mask); end
    step();
    checks++; if (reg_write !== 1'b1 || write_reg !== 3'd2 || write_data !== 16'h0022)
      begin errors++; $display("FAIL b2b_pop2 got=%0b/%0d/%h exp=1/2/0022", reg_write, write_reg, write_data); end
    step();
    checks++; if (reg_write !== 1'b0 || pending_mask !== 8'h00)
      begin errors++; $display("FAIL b2b_idle got=%0b/%h exp=0/00", reg_write, pending_mask); end
  endtask

  task automatic test_zero_reg();
    logic       exp_we;
    logic [7:0] exp_pend;
`ifdef WB_ZERO_REG_EN
    exp_we = 1'b0; exp_pend = 8'h00;
`else
    exp_we = 1'b1; exp_pend = 8'h01;
`endif
    alu_valid = 1'b1; alu_rd = 3'd0; alu_data = 16'hFFFF;
    step();
    alu_valid = 1'b0;
    checks++; if (reg_write !== exp_we) begin errors++; $display("FAIL zr_alu_we got=%0b exp=%0b", reg_write, exp_we); end
    mem_valid = 1'b1; mem_rd = 3'd0; mem_data = 16'h5A5A;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL zr_ready got=%0b exp=1", mem_ready); end
    step();
    mem_valid = 1'b0;
    checks++; if (pending_mask !== exp_pend) begin errors++; $display("FAIL zr_pend got=%h exp=%h", pending_mask, exp_pend); end
    step();
    checks++; if (reg_write !== exp_we) begin errors++; $display("FAIL zr_load_we got=%0b exp=%0b", reg_write, exp_we); end
`ifndef WB_ZERO_REG_EN
    checks++; if (write_reg !== 3'd0 || write_data !== 16'h5A5A)
      begin errors++; $display("FAIL zr_load_data got=%0d/%h exp=0/5a5a", write_reg, write_data); end
`endif
    step();
    checks++; if (reg_write !== 1'b0 || pending_mask !== 8'h00)
      begin errors++; $display("FAIL zr_idle got=%0b/%h exp=0/00", reg_write, pending_mask); end
  endtask

  task automatic test_order_err();
    mem_valid = 1'b1; mem_rd = 3'd4; mem_data = 16'h4444;
    step();
    mem_valid = 1'b0;
    checks++; if (order_err !== 1'b0) begin errors++; $display("FAIL oe_pre got=%0b exp=0", order_err); end
    alu_valid = 1'b1; alu_rd = 3'd4; alu_data = 16'hAAAA;
    step();
    alu_valid = 1'b0;
    checks++; if (reg_write !== 1'b1 || write_reg !== 3'd4 || write_data !== 16'hAAAA)
      begin errors++; $display("FAIL oe_alu got=%0b/%0d/%h exp=1/4/aaaa", reg_write, write_reg, write_data); end
    checks++; if (order_err !== 1'b1) begin errors++; $display("FAIL oe_set got=%0b exp=1", order_err); end
    step();
    checks++; if (write_data !== 16'h4444 || order_err !== 1'b1)
      begin errors++; $display("FAIL oe_load got=%h/%0b exp=4444/1", write_data, order_err); end
    step(); step();
    checks++; if (order_err !== 1'b1) begin errors++; $display("FAIL oe_sticky got=%0b exp=1", order_err); end
    // Queue a load, then reset before it can drain.
    mem_valid = 1'b1; mem_rd = 3'd6; mem_data = 16'h6666;
    step();
    mem_valid = 1'b0; reset = 1'b1;
    step();
    checks++; if (reg_write !== 1'b0 || pending_mask !== 8'h00 || order_err !== 1'b0 || mem_ready !== 1'b0)
      begin errors++; $display("FAIL oe_reset got=%0b/%h/%0b/%0b exp=0/00/0/0", reg_write, pending_mask, order_err, mem_ready); end
    reset = 1'b0;
    step();
    checks++; if (reg_write !== 1'b0 || pending_mask !== 8'h00)
      begin errors++; $display("FAIL oe_post_reset got=%0b/%h exp=0/00", reg_write, pending_mask); end
  endtask

  initial begin
    test_reset();
    test_alu_stream();
    test_load();
    test_contention();
    test_back_to_back();
    test_zero_reg();
    test_order_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that owns the register file's single write port. Merges a single-cycle ALU result stream, which is never stalled, with a variable-latency memory/load result stream, which is buffered in a small FIFO. Drives the register file write port from registered outputs. Exposes a per-register pending mask so decode can hold off writers and readers of registers with queued load results.

## Interface
Parameters:
- DATA_WIDTH, 16: result/register data width
- REGADDR_WIDTH, 3: register address width
- NUM_REGS, 1<<REGADDR_WIDTH: register count, width of pending_mask
- FIFO_DEPTH, 2: load-result buffer entries, power of two, ≥2

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  REGADDR_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  load result accepted when mem_valid && mem_ready
- mem_rd  in  REGADDR_WIDTH  load destination register
- mem_data  in  DATA_WIDTH  load data
- reg_write  out  1  register file write enable (registered)
- write_reg  out  REGADDR_WIDTH  register file write address (registered)
- write_data  out  DATA_WIDTH  register file write data (registered)
- pending_mask  out  NUM_REGS  bit r set while any FIFO entry targets r
- order_err  out  1  sticky; ALU wrote a register with a pending load

## Operation
- Reset (sync): FIFO emptied, count=0, pointers=0; reg_write=0, write_reg=0, write_data=0, pending_mask=0, order_err=0; mem_ready=0 while reset is high.
- mem_ready = (count < FIFO_DEPTH) when not in reset. Depends only on registered count, never on mem_valid or on a same-cycle dequeue.
- Accept: mem_valid && mem_ready pushes {mem_rd, mem_data} at the tail.
- Output selection each cycle, registered into reg_write/write_reg/write_data:
  - alu_valid=1: ALU result wins. FIFO head is retained.
  - else if count>0: FIFO head is popped and written.
  - else: reg_write=0. write_reg and write_data hold their previous values.
- Push and pop in the same cycle: count unchanged; both pointers advance mod FIFO_DEPTH.
- pending_mask is the OR of one-hot(rd) over valid FIFO entries. It is derived from stored state only; an entry being accepted this cycle is not yet included.
- order_err sets when alu_valid && pending_mask[alu_rd]. It clears only on reset. The ALU write still proceeds. Decode is responsible for preventing this condition by stalling on pending_mask.
- Pointers wrap to 0 after FIFO_DEPTH-1.

## Timing
- ALU path latency: 1 cycle. alu_valid at cycle N gives reg_write=1 at N+1.
- Load path minimum latency: 2 cycles. Accept at N, pop at N+1 (if no alu_valid), reg_write=1 at N+2.
- Sustained alu_valid starves the FIFO indefinitely. mem_ready drops once the FIFO is full and reasserts the cycle after the first pop.
- pending_mask bit sets the cycle after accept. It clears the cycle after the pop, which is the same cycle the write appears on the port. The register file forwards write_data in that cycle, so no read gap exists.
- Reset asserted mid-operation discards all queued entries. No write is issued in the cycle after reset.

## Configuration
- WB_ZERO_REG_EN defined: any result with rd=0 is discarded. ALU results with rd=0 produce reg_write=0. Loads with rd=0 are accepted (handshake completes) but never enqueued and never set pending_mask. order_err ignores rd=0.
- WB_ZERO_REG_EN undefined: register 0 is an ordinary register; all behaviour as above.

## Test plan
- Reset then idle: all outputs 0 and mem_ready=0 during reset; mem_ready=1 and reg_write=0 on the cycle after reset deasserts.
- ALU stream: alu_valid with rd=3, data=0x1234 at N -> reg_write=1, write_reg=3, write_data=0x1234 at N+1; no ALU at N+1 -> reg_write=0 at N+2.
- Load, no contention: accept rd=5, data=0xBEEF at N -> pending_mask=0x20 at N+1; write rd 5 = 0xBEEF at N+2; pending_mask=0 at N+2.
- Contention and full: alu_valid held 4 cycles while loads rd=1 (0x0001) and rd=2 (0x0002) are accepted -> mem_ready=0 after second accept, pending_mask=0x06; after ALU stops, writes 0x0001 then 0x0002 in order on consecutive cycles.
- Order error: load rd=4 queued, then alu_valid rd=4 -> ALU write occurs, order_err=1 next cycle and stays 1 until reset.
- WB_ZERO_REG_EN: alu rd=0 data=0xFFFF -> reg_write stays 0; load rd=0 accepted, pending_mask stays 0, no write issued.
